hit_decoder: RTL

HIT_DECODER -- requirements
Module: hit_decoder

---
 rtl/game_pkg.sv | 35 +++
 rtl/btn_sync.sv | 43 ++++
 rtl/hit_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game types: FSM state encoding and the counter-to-zone decode used by scoring and display.
// Pure declarations; no latency, no backpressure.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DECIDE  = 2'd1,
        ST_LOCKOUT = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] idx;
    } zone_t;

    // Zone 0 covers the lowest counts; the rest count down from LED_NUM-1 as cnt rises.
    function automatic zone_t zone_decode(input int unsigned cnt,
                                          input int unsigned led_num,
                                          input int unsigned cnt_lim);
        zone_t       z;
        int unsigned delta;
        delta = cnt_lim / led_num;
        z     = '0;
        if (cnt < delta) begin
            z.vld = 1'b1;
            z.idx = 32'd0;
        end else if (cnt < led_num * delta) begin
            z.vld = 1'b1;
            z.idx = led_num - (cnt / delta);
        end
        return z;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop button synchronizer with rising-edge detect, armed only after a real low is seen.
// Latency: 2 cycles to lvl_o, rise_o combinational from registers; no backpressure.
module btn_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic lvl_o,
    output logic rise_o
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_v1;
    logic r_v2;
    logic r_armed;

    // r_v1/r_v2 mark when r_s2 carries a real sample rather than its reset value,
    // so a button held through reset is not mistaken for a fresh press.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_prev  <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_s1   <= btn_i;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_v1   <= 1'b1;
            r_v2   <= r_v1;
            if (r_v2 && !r_s2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign lvl_o  = r_s2;
    assign rise_o = r_s2 & ~r_prev & r_armed;

endmodule

// File: rtl/hit_decoder.sv
// Decodes a button press against the stopwatch count into a zone, scores hits, then locks out.
// Latency: hit/miss 2 cycles after the IDLE cycle seeing the edge; no backpressure, presses outside IDLE are dropped.
module hit_decoder
    import game_pkg::*;
#(
    parameter int LED_NUM  = 10,
    parameter int CNT_LIM  = 100,
    parameter int LOCK_CYC = 4,
    parameter int SCORE_W  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [$clog2(CNT_LIM):0]   cnt_i,
    input  logic [LED_NUM-1:0]         sw_i,
    input  logic                       btn_i,
    input  logic                       clr_i,
    output logic                       hit_o,
    output logic                       miss_o,
    output logic [$clog2(LED_NUM)-1:0] zone_o,
    output logic                       zone_vld_o,
    output logic [SCORE_W-1:0]         score_o,
    output logic                       busy_o
);

    localparam int CW = $clog2(CNT_LIM) + 1;
    localparam int ZW = $clog2(LED_NUM);
    localparam int LW = $clog2(LOCK_CYC) + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt_q;
    logic [LW-1:0]   r_lock;
    logic            r_hit;
    logic            r_miss;
    logic [ZW-1:0]   r_zone;
    logic            r_zone_vld;
    logic [SCORE_W-1:0] r_score;

    logic            w_lvl;
    logic            w_rise;
    zone_t           w_dec;
    logic [ZW-1:0]   w_zone;
    logic            w_hit;
    logic            w_lock_done;

    btn_sync u_btn_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .btn_i   (btn_i),
        .lvl_o   (w_lvl),
        .rise_o  (w_rise)
    );

    assign w_dec       = zone_decode(32'(r_cnt_q), LED_NUM, CNT_LIM);
    assign w_zone      = ZW'(w_dec.idx);
    assign w_hit       = w_dec.vld & sw_i[w_zone];
    assign w_lock_done = (r_lock == LW'(LOCK_CYC - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_rise)      w_state_nxt = ST_DECIDE;
            ST_DECIDE:                   w_state_nxt = ST_LOCKOUT;
            ST_LOCKOUT: if (w_lock_done) w_state_nxt = ST_RELEASE;
            ST_RELEASE: if (!w_lvl)      w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_cnt_q    <= '0;
            r_lock     <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_zone     <= '0;
            r_zone_vld <= 1'b0;
            r_score    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_cnt_q <= cnt_i;
                    end
                end
                ST_DECIDE: begin
                    r_hit      <= w_hit;
                    r_miss     <= ~w_hit;
                    r_zone     <= w_zone;
                    r_zone_vld <= w_dec.vld;
                    r_lock     <= '0;
                end
                ST_LOCKOUT: begin
                    r_lock <= r_lock + LW'(1);
                end
                default: begin
                end
            endcase
            // Clear wins over an increment landing on the same edge.
            if (clr_i) begin
                r_score <= '0;
            end else if (r_state == ST_DECIDE && w_hit && r_score != SCORE_MAX) begin
                r_score <= r_score + SCORE_W'(1);
            end
        end
    end

    assign hit_o      = r_hit;
    assign miss_o     = r_miss;
    assign zone_o     = r_zone;
    assign zone_vld_o = r_zone_vld;
    assign score_o    = r_score;
    assign busy_o     = (r_state != ST_IDLE);

endmodule
